// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data SRAM between the CPU MEM stage (port 0) and the
// host/debug port (port 1). Arbitration is round-robin. The host may take a
// burst lock that is bounded to MAX_BURST consecutive grants. When a lock ends
// on the burst limit, the CPU is guaranteed the next grant. Read data from the
// SRAM arrives one cycle after the grant and is steered back to the port that
// issued the read.
//
// Ports
//   clk, arst                   clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0       CPU request (held until gnt0)
//   gnt0, rvalid0, rdata0       CPU grant and read return
//   req1/we1/addr1/wdata1/lock1 host request, plus burst-lock request
//   gnt1, rvalid1, rdata1       host grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM port
//   stall_cpu                   CPU is requesting but was not granted
module dmem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_cpu
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_LOCK = 1'b1;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic             state, state_n;
    logic             last;
    logic [CNT_W-1:0] burst_cnt, cnt_n, cnt_inc;
    logic             yield, yield_n;
    logic             rd_pend;
    logic             rd_owner;
    logic [DATA_W-1:0] rdata0_hold, rdata1_hold;
    logic             granted;

    // Grant decision. Grants are masked while reset is held so that nothing
    // reaches the SRAM even though the requests themselves are live.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!arst) begin
            if (state == ST_LOCK) begin
                gnt1 = req1;
            end else if (req0 && (yield || !req1 || last)) begin
                // The CPU wins when it is alone, when it is owed a slot after
                // a saturated burst, or when the host had the last grant.
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign granted   = gnt0 | gnt1;
    assign mem_en    = granted;
    assign mem_we    = gnt1 ? we1    : (gnt0 & we0);
    assign mem_addr  = gnt1 ? addr1  : addr0;
    assign mem_wdata = gnt1 ? wdata1 : wdata0;
    assign stall_cpu = req0 & ~gnt0;

    assign cnt_inc = burst_cnt + CNT_W'(1);

    // Lock and yield bookkeeping
    always_comb begin
        state_n = state;
        cnt_n   = burst_cnt;
        yield_n = (granted || !req0) ? 1'b0 : yield;
        if (state == ST_ARB) begin
            if (gnt1 && lock1) begin
                if (MAX_BURST <= 1) begin
                    // The grant that would open the lock already uses up the
                    // whole burst allowance.
                    yield_n = 1'b1;
                    cnt_n   = '0;
                end else begin
                    state_n = ST_LOCK;
                    cnt_n   = CNT_W'(1);
                end
            end
        end else begin
            if (gnt1 && (cnt_inc == BURST_MAX)) begin
                // The saturation exit takes priority over a lock1 drop in the
                // same cycle, so the CPU still gets its guaranteed slot.
                state_n = ST_ARB;
                cnt_n   = '0;
                yield_n = 1'b1;
            end else if (!lock1) begin
                state_n = ST_ARB;
                cnt_n   = '0;
            end else if (gnt1) begin
                cnt_n = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= ST_ARB;
            last        <= 1'b1;
            burst_cnt   <= '0;
            yield       <= 1'b0;
            rd_pend     <= 1'b0;
            rd_owner    <= 1'b0;
            rdata0_hold <= '0;
            rdata1_hold <= '0;
        end else begin
            state     <= state_n;
            burst_cnt <= cnt_n;
            yield     <= yield_n;
            rd_pend   <= granted & ~mem_we;
            if (granted) begin
                last     <= gnt1;
                rd_owner <= gnt1;
            end
            if (rvalid0) rdata0_hold <= mem_rdata;
            if (rvalid1) rdata1_hold <= mem_rdata;
        end
    end

    // Read return: the SRAM data is passed through in the valid cycle. Each
    // port keeps showing its last returned word afterwards.
    assign rvalid0 = rd_pend & ~rd_owner;
    assign rvalid1 = rd_pend &  rd_owner;
    assign rdata0  = rvalid0 ? mem_rdata : rdata0_hold;
    assign rdata1  = rvalid1 ? mem_rdata : rdata1_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;

    logic              clk = 1'b0;
    logic              arst;
    logic              req0, we0, gnt0, rvalid0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0, rdata0;
    logic              req1, we1, lock1, gnt1, rvalid1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1, rdata1;
    logic              mem_en, mem_we, stall_cpu;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .arst(arst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cpu(stall_cpu)
    );

    always #5 clk = ~clk;

    // SRAM instance model: one-cycle registered read
    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory contents, who owns the bus, and what is owed
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
    int                m_last;
    bit                m_locked;
    int                m_cnt;
    bit                m_yield;
    bit                m_pend;
    int                m_owner;
    logic [DATA_W-1:0] m_pdata, m_rd0, m_rd1;
    int                g_exp;

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_cnt = 0; m_yield = 0;
        m_pend = 0; m_owner = 0; m_rd0 = '0; m_rd1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the DUT against the model for the current inputs, then advance
    // the model by one clock.
    task automatic eval();
        int w;
        bit ewe;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewdata;
        @(negedge clk);
        w = -1;
        if (m_locked) begin
            if (req1) w = 1;
        end else if (req0 && m_yield) w = 0;
        else if (req0 && req1) w = (m_last == 1) ? 0 : 1;
        else if (req0) w = 0;
        else if (req1) w = 1;

        if (m_pend) begin
            if (m_owner == 0) m_rd0 = m_pdata;
            else              m_rd1 = m_pdata;
        end
        chk("gnt0", gnt0, w == 0);
        chk("gnt1", gnt1, w == 1);
        chk("mem_en", mem_en, w >= 0);
        chk("stall_cpu", stall_cpu, req0 && (w != 0));
        chk("rvalid0", rvalid0, m_pend && m_owner == 0);
        chk("rvalid1", rvalid1, m_pend && m_owner == 1);
        chk("rdata0", rdata0, m_rd0);
        chk("rdata1", rdata1, m_rd1);

        m_pend = 0;
        if (w >= 0) begin
            ewe    = (w == 1) ? we1 : we0;
            eaddr  = (w == 1) ? addr1 : addr0;
            ewdata = (w == 1) ? wdata1 : wdata0;
            chk("mem_we", mem_we, ewe);
            chk("mem_addr", mem_addr, eaddr);
            if (ewe) begin
                chk("mem_wdata", mem_wdata, ewdata);
                shadow[eaddr] = ewdata;
            end else begin
                m_pend  = 1;
                m_owner = w;
                m_pdata = shadow[eaddr];
            end
            m_last = w;
        end

        if (w >= 0 || !req0) m_yield = 0;
        if (!m_locked) begin
            if (w == 1 && lock1) begin
                m_cnt = 1;
                if (m_cnt >= MAX_BURST) begin
                    m_cnt = 0;
                    m_yield = 1;
                end else begin
                    m_locked = 1;
                end
            end
        end else begin
            if (w == 1) m_cnt++;
            if (m_cnt == MAX_BURST) begin
                m_locked = 0; m_cnt = 0; m_yield = 1;
            end else if (!lock1) begin
                m_locked = 0; m_cnt = 0;
            end
        end
        g_exp = w;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
    endtask

    initial begin
        int stalls;
        logic [DATA_W-1:0] v;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            v = $urandom;
            sram[i] = v;
            shadow[i] = v;
        end
        sram[10'h010] = 32'hDEADBEEF; shadow[10'h010] = 32'hDEADBEEF;
        sram[10'h020] = 32'h11;       shadow[10'h020] = 32'h11;
        sram[10'h021] = 32'h22;       shadow[10'h021] = 32'h22;
        mem_rdata = '0;
        idle_inputs();
        arst = 1;
        req0 = 1;
        model_reset();

        // Held in reset with a live CPU request
        #3;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_stall", stall_cpu, 1);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        tick();
        arst = 0;
        we0 = 1; addr0 = 10'h005; wdata0 = 32'h5555;
        eval();
        chk("rel_gnt0", gnt0, 1);
        chk("rel_mem_en", mem_en, 1);
        chk("rel_stall", stall_cpu, 0);
        tick();

        // CPU read of a preset word
        we0 = 0; addr0 = 10'h010;
        eval();
        chk("cpurd_gnt0", gnt0, 1);
        tick();
        req0 = 0;
        eval();
        chk("cpurd_rvalid0", rvalid0, 1);
        chk("cpurd_rdata0", rdata0, 32'hDEADBEEF);
        chk("cpurd_rvalid1", rvalid1, 0);
        tick();

        // Host write so the host holds the last grant
        req1 = 1; we1 = 1; addr1 = 10'h003; wdata1 = 32'h3333;
        eval();
        tick();

        // Contention without lock: 0,1,0,1
        req0 = 1; we0 = 1; addr0 = 10'h030; wdata0 = 32'hA0;
        req1 = 1; we1 = 1; addr1 = 10'h031; wdata1 = 32'hB1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("cont_gnt0", gnt0, (i % 2) == 0);
            chk("cont_stall", stall_cpu, (i % 2) == 1);
            tick();
        end

        // One CPU-only cycle so the host wins the next tie
        req1 = 0;
        eval();
        tick();

        // Burst lock held for 12 cycles with the CPU waiting throughout
        req1 = 1; lock1 = 1; we1 = 1; addr1 = 10'h040; wdata1 = 32'hC0;
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            eval();
            if (i < 9) begin
                chk("burst_gnt1", gnt1, i < 8);
                stalls += int'(stall_cpu);
            end
            tick();
        end
        chk("burst_stall_cnt", stalls, 8);
        idle_inputs();
        eval();
        tick();

        // Interleaved read return: host then CPU, back to back
        req1 = 1; we1 = 0; addr1 = 10'h020;
        eval();
        chk("il_gnt1", gnt1, 1);
        tick();
        req1 = 0;
        req0 = 1; we0 = 0; addr0 = 10'h021;
        eval();
        chk("il_gnt0", gnt0, 1);
        chk("il_rvalid1", rvalid1, 1);
        chk("il_rdata1", rdata1, 32'h11);
        chk("il_rvalid0_early", rvalid0, 0);
        tick();
        req0 = 0;
        eval();
        chk("il_rvalid0", rvalid0, 1);
        chk("il_rdata0", rdata0, 32'h22);
        chk("il_rvalid1_late", rvalid1, 0);
        chk("il_rdata1_hold", rdata1, 32'h11);
        tick();

        // Reset in the middle of a locked read burst
        req1 = 1; lock1 = 1; we1 = 0; addr1 = 10'h020;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("mrst_gnt1", gnt1, 1);
            tick();
        end
        arst = 1;
        #1;
        chk("mrst_rvalid1", rvalid1, 0);
        chk("mrst_gnt1_rst", gnt1, 0);
        chk("mrst_mem_en", mem_en, 0);
        model_reset();
        #1;
        arst = 0;
        lock1 = 0;
        req0 = 1; we0 = 0; addr0 = 10'h021;
        eval();
        chk("mrst_tie_gnt0", gnt0, 1);
        chk("mrst_no_rvalid", rvalid0 | rvalid1, 0);
        tick();
        idle_inputs();

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            eval();
            tick();
            if (g_exp == 0) req0 = 0;
            if (g_exp == 1) req1 = 0;
            if (!req0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1; we0 = $urandom_range(0, 1);
                    addr0 = ADDR_W'($urandom_range(0, 31)); wdata0 = $urandom;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                req0 = 0;
            end
            if (!req1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1; we1 = $urandom_range(0, 1);
                    addr1 = ADDR_W'($urandom_range(0, 31)); wdata1 = $urandom;
                    lock1 = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 3) == 0) begin
                    lock1 = 0;
                end
            end else if ($urandom_range(0, 31) == 0) begin
                req1 = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
